// File: rtl/fact_unit.sv
// fact_unit: iterative factorial engine for the FACT peripheral.
//
// Accepts an operand `n` with a `go` pulse and computes n! modulo 2^WIDTH,
// performing one multiply per clock. The result is held, with done/err
// status, until the next accepted `go`.
//
// Optional build macro:
//   FACT_OVERFLOW_CHECK_EN - when defined, `err` flags any multiply step whose
//                            full 2*WIDTH product spills past WIDTH bits.
//                            When undefined, `err` is tied low.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   go        in   start request, honoured only in IDLE or DONE
//   n         in   operand, captured on the accepted go edge
//   busy      out  high while multiplying (MULT)
//   done      out  high in DONE, result valid
//   err       out  overflow flag for the current/last operation
//   result    out  n! mod 2^WIDTH, held until the next accepted go
//   state_dbg out  current FSM state (0 IDLE, 1 MULT, 2 DONE)
//
// Handshake: go is a level-sampled request. It is accepted on any rising
// edge where the FSM is in IDLE or DONE and ignored otherwise; there is no
// ready output and requests made while busy are dropped, not queued.
module fact_unit #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   result,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N_WIDTH-1:0] CNT_ONE  = N_WIDTH'(1);
  localparam logic [WIDTH-1:0]   PROD_ONE = WIDTH'(1);

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] count_q;
  logic [WIDTH-1:0]   product_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   prod_next;
  logic               accept, step, finish;

  // Next-state and strobe decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          accept  = 1'b1;
          state_d = S_MULT;
        end
      end
      S_MULT: begin
        // Counting down to 1 means n=0 and n=1 both finish with product 1.
        if (count_q > CNT_ONE) begin
          step = 1'b1;
        end else begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FACT_OVERFLOW_CHECK_EN
  logic [2*WIDTH-1:0] full_prod;
  logic               ovf;
  logic               err_q;

  assign full_prod = {{WIDTH{1'b0}}, product_q} *
                     {{(2*WIDTH-N_WIDTH){1'b0}}, count_q};
  assign prod_next = full_prod[WIDTH-1:0];
  assign ovf       = |full_prod[2*WIDTH-1:WIDTH];

  // Sticky for one operation: cleared on accept, set by any spilling step.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (step && ovf) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // Only the low WIDTH bits are needed, so the multiply is truncated.
  assign prod_next = product_q * {{(WIDTH-N_WIDTH){1'b0}}, count_q};
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      product_q <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q   <= n;
        product_q <= PROD_ONE;
      end else if (step) begin
        product_q <= prod_next;
        count_q   <= count_q - CNT_ONE;
      end
      // result changes only on entry to DONE and holds through MULT.
      if (finish) begin
        result_q <= product_q;
      end
    end
  end

  // All outputs decode registered state only.
  assign busy      = (state_q == S_MULT);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fact_unit.sv
// tb_fact_unit: self-checking bench for fact_unit (WIDTH=32, N_WIDTH=4).
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, away from the rising edge the DUT uses.
module tb_fact_unit;

  localparam int W  = 32;
  localparam int NW = 4;

  logic          clk;
  logic          rst;
  logic          go;
  logic [NW-1:0] n;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  fact_unit #(.WIDTH(W), .N_WIDTH(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .n         (n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1;
    go  = 1'b0;
    n   = '0;
  end

  // Checking task
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: exact factorial in 64 bits (15! fits), then reduce.
  function automatic longint unsigned fact_exact(input int k);
    longint unsigned r = 1;
    for (int i = 2; i <= k; i++) r = r * longint'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] model_result(input int k);
    longint unsigned r = fact_exact(k);
    return r[W-1:0];
  endfunction

  function automatic logic model_err(input int k);
`ifdef FACT_OVERFLOW_CHECK_EN
    return (fact_exact(k) >> W) != 0;
`else
    return (k < 0);
`endif
  endfunction

  // Driver tasks
  // Called at a falling edge while the DUT is in IDLE or DONE.
  task automatic start(input int nv);
    go = 1'b1;
    n  = NW'(nv);
    exp_q.push_back(model_result(nv));
    exp_err_q.push_back(model_err(nv));
    @(negedge clk);
    go = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done_drop", done, 0);
  endtask

  // Observes the running operation; optionally pulses a stray go with n=2
  // at the given busy cycle, which must be ignored.
  task automatic wait_done(input int nv, input int stray_k);
    int busy_cyc = 0;
    int guard    = 0;
    logic [W-1:0] exp_r;
    logic         exp_e;
    while (!done && guard < 64) begin
      if (busy) busy_cyc++;
      if (guard == stray_k) begin
        go = 1'b1;
        n  = NW'(2);
      end else begin
        go = 1'b0;
      end
      guard++;
      @(negedge clk);
    end
    go = 1'b0;
    exp_r = exp_q.pop_front();
    exp_e = exp_err_q.pop_front();
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check($sformatf("busy_cycles_n%0d", nv), busy_cyc, (nv > 1) ? nv : 1);
      check("busy_low_at_done", busy, 0);
      check($sformatf("result_n%0d", nv), result, exp_r);
      check($sformatf("err_n%0d", nv), err, exp_e);
    end
  endtask

  task automatic check_hold(input int cycles, input logic [W-1:0] exp_r);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("hold_done", done, 1);
      check("hold_result", result, exp_r);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_result"}, result, 0);
  endtask

  // Stimulus and final report
  initial begin
    int nv;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle_zero("reset_idle");
    end

    // Nominal and edge operands
    start(5);  wait_done(5, -1);  check_hold(3, model_result(5));
    start(0);  wait_done(0, -1);
    start(1);  wait_done(1, -1);
    start(12); wait_done(12, -1);

    // Overflow then a clean operation
    start(13); wait_done(13, -1);
    start(3);  wait_done(3, -1);

    // Stray go during MULT is ignored
    @(negedge clk);
    start(7);  wait_done(7, 2);
    check_hold(2, model_result(7));

    // Back-to-back restart from DONE
    start(3);  wait_done(3, -1);

    // Mid-operation reset discards the operation
    start(9);
    void'(exp_q.pop_back());
    void'(exp_err_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_reset");
    start(4);  wait_done(4, -1);

    // Reset wins over a simultaneous go
    rst = 1'b1;
    go  = 1'b1;
    n   = NW'(6);
    @(negedge clk);
    check_idle_zero("rst_and_go");
    rst = 1'b0;
    go  = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_and_go_after");

    // Randomized operations, some back-to-back from DONE
    for (int t = 0; t < 25; t++) begin
      nv = $urandom_range(0, 15);
      start(nv);
      wait_done(nv, ($urandom_range(0, 3) == 0) ? 1 : -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
